// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the four byte requesters, the arbiter and the tx serializer.
// The arbiter connects through "master"; a requester/serializer model connects through "slave".
interface uart_tx_arbiter_if;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        grant_active;
  logic        lock_abort;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data, grant_id, grant_active, lock_abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data, grant_id, grant_active, lock_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART tx serializer among four byte sources.
// A grant is held for a whole message; an owner that stalls too long is revoked.
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from last_grant+1
// LOAD  | owner holds grant; accept its byte or count towards timeout
// START | tx_start/req_ready pulse visible; serializer busy not yet valid
// WAIT  | serializer busy; on release finish message or fetch next byte
module uart_tx_arbiter #(
  parameter int LOCK_TIMEOUT = 12000,
  parameter int TO_W         = 14
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_tx_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic            grant_active_q, grant_active_d;
  logic [3:0]      req_ready_q, req_ready_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            lock_abort_q, lock_abort_d;
  logic            last_flag_q, last_flag_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [TO_W-1:0] to_cnt_inc;

  logic            rr_found;
  logic [1:0]      rr_winner;
  logic [1:0]      rr_cand;

  logic            owner_valid;
  logic            owner_last;
  logic [7:0]      owner_data;

  // Search order starts just after the previous owner and wraps back to it last.
  always_comb begin
    rr_found  = 1'b0;
    rr_winner = last_grant_q;
    rr_cand   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last_grant_q + 2'(k);
      if (!rr_found && bus.req_valid[rr_cand]) begin
        rr_found  = 1'b1;
        rr_winner = rr_cand;
      end
    end
  end

  assign owner_valid = bus.req_valid[grant_id_q];
  assign owner_last  = bus.req_last[grant_id_q];
  assign owner_data  = bus.req_data[{grant_id_q, 3'b000} +: 8];

  assign to_cnt_inc  = (to_cnt_q == {TO_W{1'b1}}) ? to_cnt_q : to_cnt_q + TO_W'(1);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_flag_d    = last_flag_q;
    to_cnt_d       = to_cnt_q;
    req_ready_d    = 4'b0000;
    tx_start_d     = 1'b0;
    lock_abort_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          grant_id_d     = rr_winner;
          last_grant_d   = rr_winner;
          grant_active_d = 1'b1;
          state_d        = S_LOAD;
        end
      end

      S_LOAD: begin
        if (owner_valid) begin
          tx_data_d   = owner_data;
          last_flag_d = owner_last;
          req_ready_d = 4'b0001 << grant_id_q;
          tx_start_d  = 1'b1;
          to_cnt_d    = '0;
          state_d     = S_START;
        end else if (to_cnt_inc == TO_W'(LOCK_TIMEOUT)) begin
          // Owner stalled mid-message: revoke so the others are not starved.
          lock_abort_d   = 1'b1;
          grant_active_d = 1'b0;
          to_cnt_d       = '0;
          state_d        = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_inc;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!bus.tx_busy) begin
          if (last_flag_q) begin
            grant_active_d = 1'b0;
            state_d        = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      last_grant_q   <= 2'd3;
      grant_id_q     <= 2'd0;
      grant_active_q <= 1'b0;
      req_ready_q    <= 4'b0000;
      tx_start_q     <= 1'b0;
      tx_data_q      <= 8'h00;
      lock_abort_q   <= 1'b0;
      last_flag_q    <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      req_ready_q    <= req_ready_d;
      tx_start_q     <= tx_start_d;
      tx_data_q      <= tx_data_d;
      lock_abort_q   <= lock_abort_d;
      last_flag_q    <= last_flag_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_data      = tx_data_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_active = grant_active_q;
  assign bus.lock_abort   = lock_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a serializer model drive
// the DUT; a monitor pops hand-computed expected bytes/aborts as the DUT emits them.
module tb_uart_tx_arbiter;
  localparam int LOCK_TIMEOUT = 12000;
  localparam int TO_W         = 14;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.LOCK_TIMEOUT(LOCK_TIMEOUT), .TO_W(TO_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    bit         abort;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [8:0] rq[4][$];
  logic [3:0] adv       = 4'b0000;
  logic [3:0] drv_valid = 4'b0000;
  logic [3:0] drv_last  = 4'b0000;
  logic [31:0] drv_data = 32'h0;
  logic [8:0] drv_hd;

  logic       ser_busy = 1'b0;
  logic       ser_arm  = 1'b0;
  logic [7:0] ser_data = 8'h00;
  int         ser_len  = 4;
  int         ser_rem  = 0;
  int         fall_cyc = 0;

  assign bus.req_valid = drv_valid;
  assign bus.req_last  = drv_last;
  assign bus.req_data  = drv_data;
  assign bus.tx_busy   = ser_busy;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting (cycle %0d)", name, cyc);
  endtask

  task automatic push_req(input int id, input logic [7:0] d, input bit last);
    rq[id].push_back({last, d});
  endtask

  task automatic expect_byte(input int id, input logic [7:0] d);
    exp_q.push_back('{abort: 1'b0, id: 2'(id), data: d});
  endtask

  task automatic expect_abort(input int id);
    exp_q.push_back('{abort: 1'b1, id: 2'(id), data: 8'h00});
  endtask

  // Stimulus observes/drives at negedge+2; serializer +0, monitor +1, requesters +3.
  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic wait_start(input int limit, output int at);
    at = -1;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (bus.tx_start) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timeout_fail("wait_tx_start");
  endtask

  task automatic wait_fall(input int limit);
    bit seen = 0;
    bit done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      tick();
      if (ser_busy) seen = 1;
      if (seen && !ser_busy) done = 1;
    end
    if (!done) timeout_fail("wait_busy_fall");
  endtask

  task automatic wait_idle(input int limit);
    bit done = 0;
    for (int n = 0; n < limit && !done; n++) begin
      tick();
      if (exp_q.size() == 0 && !bus.grant_active && !ser_busy && !ser_arm) done = 1;
    end
    if (!done) timeout_fail("wait_idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"},    32'(bus.req_ready), 32'h0);
    chk({tag, "_tx_start"},     32'(bus.tx_start), 32'h0);
    chk({tag, "_tx_data"},      32'(bus.tx_data), 32'h0);
    chk({tag, "_grant_id"},     32'(bus.grant_id), 32'h0);
    chk({tag, "_grant_active"}, 32'(bus.grant_active), 32'h0);
    chk({tag, "_lock_abort"},   32'(bus.lock_abort), 32'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) rq[i].delete();
  endtask

  // Serializer: busy from the cycle after tx_start for ser_len sampled cycles.
  always @(negedge clock) begin
    if (!reset_n) begin
      ser_busy = 1'b0;
      ser_arm  = 1'b0;
    end else if (bus.tx_start) begin
      ser_arm  = 1'b1;
      ser_data = bus.tx_data;
    end else if (ser_arm) begin
      ser_arm  = 1'b0;
      ser_busy = 1'b1;
      ser_rem  = ser_len;
    end else if (ser_busy) begin
      if (ser_rem <= 1) begin
        ser_busy = 1'b0;
        fall_cyc = cyc;
      end else begin
        ser_rem--;
      end
    end
  end

  // Requesters: hold the head byte until req_ready, advance in the following cycle.
  always @(negedge clock) begin
    #3;
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        adv[i] = 1'b0;
      end else begin
        if (adv[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        adv[i] = bus.req_ready[i];
      end
      drv_hd             = (rq[i].size() > 0) ? rq[i][0] : 9'h000;
      drv_valid[i]       = (rq[i].size() > 0);
      drv_last[i]        = drv_hd[8];
      drv_data[8*i +: 8] = drv_hd[7:0];
    end
  end

  always @(negedge clock) begin
    #1;
    if (reset_n) begin
      if (bus.tx_start) begin
        chk("start_while_busy", 32'(ser_busy), 32'h0);
        if (exp_q.size() == 0 || exp_q[0].abort) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: got id %0d data 0x%0h, expected no byte", bus.grant_id, bus.tx_data);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          mon_e = exp_q.pop_front();
          chk("start_grant_id", 32'(bus.grant_id), 32'(mon_e.id));
          chk("start_tx_data",  32'(bus.tx_data),  32'(mon_e.data));
          chk("start_req_ready", 32'(bus.req_ready), 32'(4'b0001 << mon_e.id));
        end
      end else if (bus.req_ready != 4'b0000) begin
        chk("ready_without_start", 32'(bus.req_ready), 32'h0);
      end
      if (bus.lock_abort) begin
        chk("abort_req_ready", 32'(bus.req_ready), 32'h0);
        if (exp_q.size() == 0 || !exp_q[0].abort) begin
          checks++;
          failures++;
          $display("FAIL unexpected_abort: got abort of id %0d, expected no abort", bus.grant_id);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          mon_e = exp_q.pop_front();
          chk("abort_grant_id", 32'(bus.grant_id), 32'(mon_e.id));
        end
      end
      if (ser_busy) chk("tx_data_stable", 32'(bus.tx_data), 32'(ser_data));
    end
  end

  initial begin
    int sc;
    int pc;
    int ac;

    // Round-robin: everyone has two single-byte messages from reset.
    ser_len = 4;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_req(i, 8'(8'h10 * (i + 1)), 1'b1);
      push_req(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) expect_byte(i, 8'(8'h10 * (i + 1) + r));
    repeat (3) tick();
    check_reset_outputs("por");
    reset_n = 1'b1;
    wait_idle(400);

    // Single byte from requester 0 with a real-baud busy time.
    ser_len = 12500;
    push_req(0, 8'h55, 1'b1);
    expect_byte(0, 8'h55);
    pc = cyc;
    wait_start(20, sc);
    chk("idle_start_latency", 32'(sc - pc), 32'd2);
    wait_fall(13000);
    tick();
    chk("single_release_grant_active", 32'(bus.grant_active), 32'h0);
    wait_idle(20);

    // Message lock: requester 2 must wait for requester 1's two-byte message.
    ser_len = 3;
    push_req(1, 8'h48, 1'b0);
    push_req(1, 8'h49, 1'b1);
    push_req(2, 8'h21, 1'b1);
    expect_byte(1, 8'h48);
    expect_byte(1, 8'h49);
    expect_byte(2, 8'h21);
    wait_start(20, sc);
    wait_fall(20);
    wait_start(20, sc);
    chk("next_byte_latency", 32'(sc - (fall_cyc + 1)), 32'd1);
    wait_idle(100);

    // Lock timeout: requester 3 abandons its message after one byte.
    push_req(3, 8'h0A, 1'b0);
    expect_byte(3, 8'h0A);
    expect_abort(3);
    wait_start(20, sc);
    wait_fall(20);
    ac = -1;
    for (int n = 0; n < LOCK_TIMEOUT + 50; n++) begin
      tick();
      if (bus.lock_abort) begin
        ac = cyc;
        break;
      end
    end
    if (ac < 0) begin
      timeout_fail("wait_lock_abort");
    end else begin
      chk("abort_timing", 32'(ac - (fall_cyc + 1)), 32'(LOCK_TIMEOUT));
      chk("abort_grant_active", 32'(bus.grant_active), 32'h0);
      chk("abort_grant_id_hold", 32'(bus.grant_id), 32'd3);
    end
    push_req(0, 8'h77, 1'b1);
    push_req(3, 8'h0B, 1'b1);
    expect_byte(0, 8'h77);
    expect_byte(3, 8'h0B);
    wait_idle(100);

    // Reset during WAIT of requester 1's message, then requester 2 alone.
    ser_len = 40;
    push_req(1, 8'h61, 1'b0);
    push_req(1, 8'h62, 1'b1);
    expect_byte(1, 8'h61);
    wait_start(20, sc);
    repeat (5) tick();
    do_reset();
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    reset_n = 1'b1;
    push_req(2, 8'h33, 1'b1);
    expect_byte(2, 8'h33);
    wait_idle(100);

    // Second reset with owner 1: afterwards 1 must win over 2 (search restarts at 0).
    push_req(1, 8'h63, 1'b0);
    push_req(1, 8'h64, 1'b1);
    expect_byte(1, 8'h63);
    wait_start(20, sc);
    repeat (5) tick();
    do_reset();
    #1;
    chk("reset2_tx_start", 32'(bus.tx_start), 32'h0);
    chk("reset2_grant_active", 32'(bus.grant_active), 32'h0);
    repeat (2) tick();
    reset_n = 1'b1;
    push_req(1, 8'h65, 1'b1);
    push_req(2, 8'h34, 1'b1);
    expect_byte(1, 8'h65);
    expect_byte(2, 8'h34);
    wait_idle(200);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
